scmp_bus_tracer: RTL and testbench

Synthesizable bus-cycle capture block that sits directly downstream of the `scmp` core's external bus. It snoops `ADS_n`/`RD_n`/`WR_n`, latches the high address nibble and status flags multiplexed on `D_o` during the address strobe, and reassembles each completed read or write into one packed record. Records are buffered in a FIFO and drained by a host through a valid/ready port. This moves the bus-dump function out of the bench and into hardware usable on target.

---
 rtl/scmp_bus_tracer.sv | 238 +++++++++++++++++++++++
 tb/tb_scmp_bus_tracer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_tracer.sv
`default_nettype none
// ============================================================================
// Module   : scmp_bus_tracer
// Purpose  : Snoops the scmp external bus (ADS_n/RD_n/WR_n). Each completed
//            read or write becomes one packed record, and records are queued
//            in a FIFO that a host drains through a valid/ready port.
// Options  : SCMP_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp (REC_W = 48).
// Revision : 1.0 - initial release
// ============================================================================
module scmp_bus_tracer #(
  parameter int DEPTH = 16,
`ifdef SCMP_TRACE_TIMESTAMP_EN
  localparam int REC_W = 48
`else
  localparam int REC_W = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en,
  input  logic                     ADS_n,
  input  logic                     RD_n,
  input  logic                     WR_n,
  input  logic [11:0]              addr,
  input  logic [7:0]               D_o,
  input  logic [7:0]               D_i,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [REC_W-1:0]         rec_data,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int                c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]     c_full    = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]     c_one     = (c_aw+1)'(1);
  localparam logic [1:0]        c_type_rd = 2'b01;
  localparam logic [1:0]        c_type_wr = 2'b10;
  localparam logic [1:0]        c_type_cf = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_STROBE = 2'd2,
    S_PUSH   = 2'd3
  } state_t;

  state_t            r_state;
  logic [15:0]       r_addr;
  logic [3:0]        r_flags;
  logic [1:0]        r_type;
  logic [7:0]        r_data;

  logic              w_ads_take;
  logic              w_strobe_low;
  logic [1:0]        w_new_type;
  logic [REC_W-1:0]  w_record;

  // FIFO storage; the head entry is mirrored in r_head so rec_data is a flop
  logic [REC_W-1:0]  r_mem [DEPTH];
  logic [REC_W-1:0]  r_head;
  logic              r_valid;
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw-1:0]   w_rd_next;
  logic [c_aw:0]     r_level;
  logic [c_aw:0]     w_level_next;
  logic              r_ovf;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_ovf_set;

  // An address strobe only starts a capture while tracing is enabled, in any state
  assign w_ads_take = !ADS_n && trace_en;

  // Strobe classification: conflict wins when both strobes are low together
  always_comb begin
    w_new_type = c_type_wr;
    if (!RD_n && !WR_n)
      w_new_type = c_type_cf;
    else if (!RD_n)
      w_new_type = c_type_rd;
  end

  // Is the strobe belonging to the latched cycle type still asserted
  always_comb begin
    w_strobe_low = 1'b0;
    case (r_type)
      c_type_rd: w_strobe_low = !RD_n;
      c_type_wr: w_strobe_low = !WR_n;
      default:   w_strobe_low = !RD_n || !WR_n;
    endcase
  end

  // Address/flag capture: every accepted ADS (re)latches, which also implements abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 16'h0000;
      r_flags <= 4'h0;
    end else if (w_ads_take) begin
      r_addr  <= {D_o[3:0], addr};
      r_flags <= D_o[7:4];
    end
  end

  // Bus-cycle FSM: arm on ADS, track the strobe, hand one record to the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_type  <= c_type_rd;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ads_take)
            r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!trace_en) begin
            r_state <= S_IDLE;
          end else if (!ADS_n) begin
            r_state <= S_ARMED;
          end else if (!RD_n || !WR_n) begin
            r_type  <= w_new_type;
            r_data  <= (w_new_type == c_type_rd) ? D_i : D_o;
            r_state <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (!ADS_n) begin
            // pending cycle is dropped; a new one arms only if tracing is on
            r_state <= trace_en ? S_ARMED : S_IDLE;
          end else if (w_strobe_low) begin
            r_data <= (r_type == c_type_rd) ? D_i : D_o;
          end else begin
            r_state <= S_PUSH;
          end
        end
        default: begin
          r_state <= w_ads_take ? S_ARMED : S_IDLE;
        end
      endcase
    end
  end

`ifdef SCMP_TRACE_TIMESTAMP_EN
  logic [15:0] r_ts_cnt;
  logic [15:0] r_ts;

  // Free-running cycle counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ts_cnt <= 16'h0000;
    else
      r_ts_cnt <= r_ts_cnt + 16'h0001;
  end

  // Stamp taken on the same edge that samples the address strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ts <= 16'h0000;
    else if (w_ads_take)
      r_ts <= r_ts_cnt;
  end

  assign w_record = {r_ts, 2'b00, r_type, r_flags, r_addr, r_data};
`else
  assign w_record = {2'b00, r_type, r_flags, r_addr, r_data};
`endif

  assign w_push    = (r_state == S_PUSH);
  assign w_pop     = r_valid && rec_ready;
  assign w_full    = (r_level == c_full);
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_rd_next = r_rd_ptr + 1'b1;

  // Occupancy after this edge's push/pop
  always_comb begin
    w_level_next = r_level;
    if (w_wr && !w_pop)
      w_level_next = r_level + c_one;
    else if (!w_wr && w_pop)
      w_level_next = r_level - c_one;
  end

  // Record storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= w_record;
  end

  // Pointers, occupancy and the registered head entry (zero-bubble refill)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= w_rd_next;
      r_level <= w_level_next;
      r_valid <= (w_level_next != '0);
      if (w_pop) begin
        if (r_level > c_one)
          r_head <= r_mem[w_rd_next];
        else if (w_wr)
          r_head <= w_record;
      end else if (w_wr && (r_level == '0)) begin
        r_head <= w_record;
      end
    end
  end

  // Sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (w_ovf_set)
      r_ovf <= 1'b1;
    else if (ovf_clr)
      r_ovf <= 1'b0;
  end

  assign rec_valid = r_valid;
  assign rec_data  = r_head;
  assign ovf       = r_ovf;
  assign level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scmp_bus_tracer
// Purpose  : Self-checking bench for scmp_bus_tracer (DEPTH = 4). Expected
//            records go into a queue; a monitor compares each popped record.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scmp_bus_tracer;

`ifdef SCMP_TRACE_TIMESTAMP_EN
  localparam int REC_W = 48;
`else
  localparam int REC_W = 32;
`endif

  logic             clk;
  logic             rst_n;
  logic             trace_en;
  logic             ADS_n;
  logic             RD_n;
  logic             WR_n;
  logic [11:0]      addr;
  logic [7:0]       D_o;
  logic [7:0]       D_i;
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;
  logic             ovf;
  logic             ovf_clr;
  logic [2:0]       level;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Records 0..3 of the overflow burst (addr 0x0100+i, data 0x10+i, read)
  logic [31:0] ovf_exp [4] = '{32'h10010010, 32'h10010111, 32'h10010212, 32'h10010313};

  scmp_bus_tracer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trace_en  (trace_en),
    .ADS_n     (ADS_n),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .addr      (addr),
    .D_o       (D_o),
    .D_i       (D_i),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_data  (rec_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete bus cycle: ADS, nlow samples of the strobe, release, push edge
  task automatic bus_cycle(input logic [1:0] kind, input logic [15:0] a, input logic [3:0] fl,
                           input logic [7:0] d, input int nlow, input bit exp_en,
                           input logic [31:0] exp_val);
    ADS_n = 1'b0;
    D_o   = {fl, a[15:12]};
    addr  = a[11:0];
    step();
    ADS_n = 1'b1;
    D_o   = d;
    D_i   = d;
    RD_n  = !kind[0];
    WR_n  = !kind[1];
    repeat (nlow) step();
    RD_n  = 1'b1;
    WR_n  = 1'b1;
    step();
    if (exp_en) exp_q.push_back(exp_val);
    step();
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int k = 0; k < 20 && level != 3'd0; k++) step();
    chk("drain_level", 64'(level), 64'd0);
  endtask

  // Scoreboard monitor: every accepted record is matched against the queue head
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected got %0h want none", rec_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rec_data[31:0] !== e) begin
          errors++;
          $display("FAIL rec_data got %0h want %0h", rec_data[31:0], e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; trace_en = 1'b1; ADS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    addr = '0; D_o = '0; D_i = '0; rec_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_data",  64'(rec_data),  64'd0);
    chk("rst_ovf",   64'(ovf),       64'd0);
    chk("rst_level", 64'(level),     64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Read: flags 5, addr A123, data 77, strobe low two samples
    ADS_n = 1'b0; D_o = 8'h5A; addr = 12'h123; step();
    ADS_n = 1'b1; RD_n = 1'b0; D_i = 8'h77; D_o = 8'h00; step(); step();
    RD_n = 1'b1; step();
    chk("rd_valid_edgeN", 64'(rec_valid), 64'd0);
    exp_q.push_back(32'h15A12377);
    step();
    chk("rd_valid_edgeN1", 64'(rec_valid), 64'd1);
    chk("rd_level", 64'(level), 64'd1);
    chk("rd_head", 64'(rec_data[31:0]), 64'h15A12377);
    drain();

    // Write: data changes while WR_n low, last sample wins
    ADS_n = 1'b0; D_o = 8'h03; addr = 12'hFFF; step();
    ADS_n = 1'b1; WR_n = 1'b0; D_o = 8'h11; step();
    D_o = 8'h22; step();
    WR_n = 1'b1; D_o = 8'h00; step();
    exp_q.push_back(32'h203FFF22);
    step();
    drain();

    // Abort: second ADS replaces the first address
    ADS_n = 1'b0; D_o = 8'h01; addr = 12'h111; step();
    D_o = 8'h92; addr = 12'hBCD; step();
    ADS_n = 1'b1; RD_n = 1'b0; D_i = 8'h3C; D_o = 8'h00; step();
    RD_n = 1'b1; step();
    exp_q.push_back(32'h192BCD3C);
    step();
    drain();

    // Strobe conflict
    bus_cycle(2'b11, 16'h0456, 4'hF, 8'hEE, 1, 1'b1, 32'h3F0456EE);
    drain();

    // Tracing disabled: no record
    trace_en = 1'b0;
    bus_cycle(2'b01, 16'h1234, 4'h0, 8'h55, 1, 1'b0, 32'h0);
    chk("dis_level", 64'(level), 64'd0);
    trace_en = 1'b1;

    // Overflow with host stalled
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      bus_cycle(2'b01, 16'h0100 + 16'(i), 4'h0, 8'h10 + 8'(i), 1, i < 4, (i < 4) ? ovf_exp[i % 4] : 32'h0);
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_head", 64'(rec_data[31:0]), 64'h10010010);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", 64'(ovf), 64'd0);
    chk("ovf_clr_level", 64'(level), 64'd4);

    // Push and pop on the same edge while full
    ADS_n = 1'b0; D_o = 8'h00; addr = 12'h200; step();
    ADS_n = 1'b1; RD_n = 1'b0; D_i = 8'hA5; step();
    RD_n = 1'b1; step();
    rec_ready = 1'b1;
    exp_q.push_back(32'h100200A5);
    step();
    rec_ready = 1'b0;
    chk("pp_level", 64'(level), 64'd4);
    chk("pp_ovf", 64'(ovf), 64'd0);
    chk("pp_head", 64'(rec_data[31:0]), 64'h10010111);
    drain();

    // Reset mid-STROBE with 3 records queued
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      bus_cycle(2'b01, 16'h0300 + 16'(i), 4'h0, 8'h30 + 8'(i), 1, 1'b0, 32'h0);
    chk("mr_level_pre", 64'(level), 64'd3);
    ADS_n = 1'b0; D_o = 8'h00; addr = 12'h3FF; step();
    ADS_n = 1'b1; RD_n = 1'b0; D_i = 8'h99; step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(rec_valid), 64'd0);
    chk("mr_level", 64'(level), 64'd0);
    RD_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    rec_ready = 1'b1;
    repeat (4) step();
    chk("mr_level_post", 64'(level), 64'd0);
    chk("mr_valid_post", 64'(rec_valid), 64'd0);

`ifdef SCMP_TRACE_TIMESTAMP_EN
    // Stamp of an ADS sampled on the sixth edge after release is 5
    rec_ready = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) step();
    bus_cycle(2'b01, 16'h0ABC, 4'h0, 8'h01, 1, 1'b1, 32'h100ABC01);
    chk("ts_first", 64'(rec_data[REC_W-1:32]), 64'd5);
    drain();
    // Stamp after 65539 edges wraps to 3
    rec_ready = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (65539) step();
    bus_cycle(2'b01, 16'h0ABD, 4'h0, 8'h02, 1, 1'b1, 32'h100ABD02);
    chk("ts_wrap", 64'(rec_data[REC_W-1:32]), 64'd3);
    drain();
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
